// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS32 IF-stage fetch controller.
package if_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } if_state_e;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: drives the PC register and runs a single-outstanding imem handshake.
// Optional misaligned-PC trap is enabled by defining IF_MISALIGN_CHECK_EN.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] PC_IF,
    output logic [31:0] Next_PC_IF,
    output logic        pc_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_IF,
    output logic        instr_valid,
    input  logic        id_stall,
    output logic        fetch_misalign
);

    if_state_e   state_q, state_d;
    logic        kill_q, kill_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic        misalign_q, misalign_d;
    logic        pc_misaligned;

`ifdef IF_MISALIGN_CHECK_EN
    assign pc_misaligned = (PC_IF[1:0] != 2'b00);
`else
    // Never set, so misalign_q stays at its reset value of zero.
    assign pc_misaligned = 1'b0;
`endif

    assign imem_addr      = PC_IF;
    assign Instr_IF       = instr_q;
    assign instr_valid    = instr_valid_q;
    assign fetch_misalign = misalign_q;

    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        misalign_d    = misalign_q;
        imem_req      = 1'b0;
        Next_PC_IF    = redirect ? redirect_pc : PC_IF + PC_INCR;
        pc_stall      = ~redirect;

        if (redirect) begin
            misalign_d = 1'b0;
        end

        case (state_q)
            S_BOOT: begin
                Next_PC_IF = RESET_PC;
                pc_stall   = 1'b0;
                state_d    = S_REQ;
            end
            S_REQ: begin
                if (pc_misaligned) begin
                    if (!redirect) begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    imem_req = 1'b1;
                    // A redirect while the request is accepted leaves a word in flight to discard.
                    if (imem_ready) begin
                        state_d = S_WAIT;
                        kill_d  = redirect;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || !id_stall) begin
                    pc_stall      = 1'b0;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= S_BOOT;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            misalign_q    <= misalign_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomised scoreboard bench for if_fetch_ctrl with a PC register and a variable-latency imem.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] PC_IF = '0;
    logic [31:0] Next_PC_IF;
    logic        pc_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr_IF;
    logic        instr_valid;
    logic        id_stall;
    logic        fetch_misalign;

    if_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .PC_IF(PC_IF), .Next_PC_IF(Next_PC_IF),
        .pc_stall(pc_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .Instr_IF(Instr_IF),
        .instr_valid(instr_valid), .id_stall(id_stall), .fetch_misalign(fetch_misalign)
    );

    always #5 Clk = ~Clk;

    // The PC register this controller pairs with.
    always @(posedge Clk) if (!pc_stall) PC_IF <= Next_PC_IF;

    typedef struct { logic [31:0] word; logic [31:0] pc; } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural view of the fetch stream.
    bit          m_boot, m_pending, m_hold, m_stale, m_mis;
    logic [31:0] m_pc, m_pend_pc, m_word, mem_addr;
    int          m_lat, late_cnt;
    int          k_redir, k_stall, k_ready, k_maxlat, k_spur;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    function automatic bit misaligned(input logic [31:0] a);
`ifdef IF_MISALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        logic [31:0] rp;
        int r;
        redirect = ($urandom_range(0, 99) < k_redir);
        rp = $urandom;
        r  = $urandom_range(0, 15);
        if (r == 0)      rp = 32'hFFFF_FFFC;
        else if (r == 1) rp = 32'h0000_1000;
        else if (r == 2) rp = 32'h0000_0002;
        else             rp[1:0] = 2'b00;
        redirect_pc = rp;
        id_stall   = ($urandom_range(0, 99) < k_stall);
        imem_ready = ($urandom_range(0, 99) < k_ready);
        imem_rdata = $urandom;
        if (m_pending && m_lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mem_addr);
        end else if (!m_pending && (late_cnt > 0 || $urandom_range(0, 99) < k_spur)) begin
            imem_rvalid = 1'b1;
        end else begin
            imem_rvalid = 1'b0;
        end
        if (late_cnt > 0) late_cnt--;
    endtask

    task automatic check_update();
        bit req_state, mis_now, consume;
        req_state = !m_boot && !m_pending && !m_hold;
        mis_now   = req_state && misaligned(m_pc);
        if (!m_boot) chk("pc_if", PC_IF, m_pc);
        chk("imem_addr", imem_addr, PC_IF);
        chk("imem_req", 32'(imem_req), 32'(req_state && !mis_now));
        chk("pc_stall", 32'(pc_stall), 32'(!(m_boot || redirect || (m_hold && !id_stall))));
        chk("next_pc", Next_PC_IF, m_boot ? RST_PC : (redirect ? redirect_pc : m_pc + 32'd4));
        chk("instr_valid", 32'(instr_valid), 32'(m_hold));
        if (m_hold) chk("instr_hold", Instr_IF, m_word);
        chk("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));

        consume = m_hold && !id_stall && !redirect;
        if (m_boot) begin
            m_boot = 1'b0;
            m_pc   = RST_PC;
        end else begin
            if (m_pending) begin
                if (imem_rvalid) begin
                    m_pending = 1'b0;
                    if (!(m_stale || redirect)) begin
                        m_hold = 1'b1;
                        m_word = word_of(m_pend_pc);
                        sb.push_back('{word: m_word, pc: m_pend_pc});
                    end
                end else begin
                    m_stale = m_stale | redirect;
                    m_lat--;
                end
            end else if (m_hold) begin
                if (redirect || !id_stall) m_hold = 1'b0;
            end else if (mis_now) begin
                if (!redirect) m_mis = 1'b1;
            end else if (imem_ready) begin
                m_pending = 1'b1;
                m_pend_pc = m_pc;
                mem_addr  = imem_addr;
                m_stale   = redirect;
                m_lat     = $urandom_range(0, k_maxlat);
            end
            if (redirect) begin
                m_mis = 1'b0;
                m_pc  = redirect_pc;
            end else if (consume) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge Clk);
        check_update();
        @(posedge Clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_knobs(input int rd, input int st, input int rdy, input int lat, input int sp);
        k_redir = rd; k_stall = st; k_ready = rdy; k_maxlat = lat; k_spur = sp;
    endtask

    task automatic check_reset_outputs();
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_if", Instr_IF, 32'd0);
        chk("rst_misalign", 32'(fetch_misalign), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_pc_stall", 32'(pc_stall), 32'd0);
        chk("rst_next_pc", Next_PC_IF, RST_PC);
    endtask

    task automatic release_reset();
        Rst_n     = 1'b1;
        m_boot    = 1'b1;
        m_pending = 1'b0;
        m_hold    = 1'b0;
        m_mis     = 1'b0;
        m_lat     = 0;
    endtask

    // Abort a fetch with reset once the model reaches the wanted phase.
    task automatic reset_during(input bit want_hold);
        int n = 0;
        while (n < 200 && !(want_hold ? m_hold : m_pending)) begin
            cycle();
            n++;
        end
        chk(want_hold ? "reach_hold" : "reach_wait", 32'(want_hold ? m_hold : m_pending), 32'd1);
        Rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        repeat (2) @(posedge Clk);
        #1;
        release_reset();
        late_cnt = 2;
    endtask

    bit prev_valid = 1'b0;
    always @(negedge Clk) begin
        exp_t e;
        if (Rst_n && instr_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: instruction %h presented with none expected at %0t", Instr_IF, $time);
            end else begin
                e = sb.pop_front();
                chk("sb_word", Instr_IF, e.word);
                chk("sb_pc", PC_IF, e.pc);
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        Rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        late_cnt = 0; m_pc = RST_PC; m_word = '0; m_pend_pc = '0; mem_addr = '0; m_stale = 1'b0;
        set_knobs(0, 0, 100, 0, 0);
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs();
        release_reset();

        run(12);                      // zero-wait, no stalls: one instruction per three cycles
        set_knobs(0, 80, 100, 0, 0);
        run(40);                      // long IF/ID back-pressure
        set_knobs(12, 35, 60, 3, 10);
        run(1500);
        set_knobs(10, 30, 100, 3, 0);
        reset_during(1'b0);
        run(200);
        reset_during(1'b1);
        set_knobs(15, 50, 50, 4, 15);
        run(800);

        set_knobs(0, 0, 100, 0, 0);
        run(12);
        @(negedge Clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
